// File: rtl/mwb_elastic_stage.sv
// mwb_elastic_stage: elastic MEM->WB pipeline stage.
// DEPTH-entry circular FIFO of writeback bundles with valid/ready on both
// sides and a synchronous flush. All state updates on the falling clock edge.
// Optional macro MWB_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module mwb_elastic_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rd_data,
    input  logic [DATA_W-1:0] in_wd,
    input  logic [ADDR_W-1:0] in_wr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rd_data,
    output logic [DATA_W-1:0] out_wd,
    output logic [ADDR_W-1:0] out_wr,
    output logic [CNT_W-1:0]  count
`ifdef MWB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int ENT_W = CTRL_W + 2 * DATA_W + ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [CTRL_W-1:0] head_ctrl;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode and head-entry presentation (ctrl gated when empty).
    always_comb begin
        in_ready  = (cnt_q < CNT_FULL);
        out_valid = (cnt_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        head      = mem[rptr];
        {head_ctrl, out_rd_data, out_wd, out_wr} = head;
        out_ctrl  = out_valid ? head_ctrl : '0;
        count     = cnt_q;
    end

    // Pointers and occupancy; flush overrides any concurrent push/pop.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; cleared on reset only, flush leaves contents stale.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush && push) begin
            mem[wptr] <= {in_ctrl, in_rd_data, in_wd, in_wr};
        end
    end

`ifdef MWB_STALL_CNT_EN
    // Count edges where MEM is blocked by a full stage; saturating, reset-only clear.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mwb_elastic_stage.md
Name: mwb_elastic_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Holds up to DEPTH in-flight MEM→WB bundles in an elastic FIFO, with a valid/ready handshake on both sides and a synchronous flush.
- Each bundle carries DM read data, ALU/write data, write-register index and CTRL_W writeback control bits.
- Sits between the MEM stage and register-file writeback, so WB back-pressure (e.g. shared write port) no longer has to freeze the whole pipe.

Parameters:
- DATA_W, 32, width of both data lanes.
- ADDR_W, 5, width of write-register index.
- CTRL_W, 2, writeback control bits; bit0 = RegWrite, bit1 = MemtoReg.
- DEPTH, 2, number of entries; legal values 1 to 8.
- CNT_W, 4, width of occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM side presents a bundle.
- in_ready  out  1  stage can accept a bundle at the next falling edge.
- in_ctrl  in  CTRL_W  writeback control from MEM.
- in_rd_data  in  DATA_W  DM read data.
- in_wd  in  DATA_W  ALU/write data.
- in_wr  in  ADDR_W  destination register.
- flush  in  1  synchronous discard of all entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB consumes the head at the next falling edge.
- out_ctrl  out  CTRL_W  head control; forced to 0 when out_valid=0.
- out_rd_data  out  DATA_W  head DM read data.
- out_wd  out  DATA_W  head write data.
- out_wr  out  ADDR_W  head destination register.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-transfer):
  - count=0, out_valid=0, in_ready=1.
  - All stored entries cleared to 0, so out_ctrl/out_rd_data/out_wd/out_wr read 0.
  - Read and write pointers return to 0.
- Storage: circular buffer of DEPTH entries. Read/write pointers wrap from DEPTH-1 to 0, including non-power-of-2 DEPTH.
- in_ready = (count < DEPTH). It depends only on state, never combinationally on out_ready.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- out_valid = (count != 0). out_* show the entry at the read pointer. When count=0, out_ctrl=0, which guarantees no spurious RegWrite.
- Latency: a bundle pushed at falling edge N is visible on out_* after edge N. Minimum latency is 1 edge; there is no combinational in→out path.
- Per falling edge, when flush=0:
  - push only: write entry, wptr+1, count+1.
  - pop only: rptr+1, count-1.
  - push and pop together: both pointers advance, count unchanged. When full, in_ready=0, so no push occurs even if a pop happens on that edge.
  - neither: hold.
- Flush (flush=1 at a falling edge):
  - count←0 and rptr←wptr←0.
  - Any concurrent push is dropped and any concurrent pop is ignored; flush wins.
  - Entry contents need not be cleared, but out_ctrl reads 0 afterwards via the out_valid gating.
- Empty boundary: pop is impossible because out_valid=0.
- Full boundary: count=DEPTH, in_ready=0, and in_valid is ignored.
- DEPTH=1: behaves as a single register with handshake. Throughput is 1 bundle per 2 edges under continuous flow.
- count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: MWB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Increments at each falling edge where in_valid=1 and in_ready=0; saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: fill 2 entries, pulse rst=0 between edges → count=0, out_valid=0, out_ctrl=0, out_wr=0 immediately, without waiting for a clock edge.
- Single bundle, DEPTH=2, out_ready=1: push ctrl=2'b11, rd=32'hDEADBEEF, wd=32'h0000_1234, wr=5'd7 → out_* match after 1 falling edge, and count returns to 0 one edge later.
- Fill to full, out_ready=0: 2 pushes → count=2, in_ready=0. A 3rd in_valid is ignored. Raise out_ready → bundles pop in FIFO order.
- Simultaneous push and pop at count=1 for 10 edges with DEPTH=3 and wr=1..10 → count stays 1, outputs in order 1..10, pointers wrap cleanly.
- Flush with concurrent push at count=2 → count=0, out_valid=0, and the pushed bundle never appears on out_*.
- MWB_STALL_CNT_EN defined: hold full with in_valid=1 for 5 edges → stall_cnt=5; flush → stall_cnt stays 5.
